// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: reads four bytes per instruction from byte-wide memory,
// streams them to the IR with slot codes, owns the PC and handshakes with decode.
module fetch_sequencer #(
  parameter int unsigned                ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]      RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [7:0]            mem_data,
  output logic [7:0]            instruction,
  output logic [2:0]            ir_write,
  output logic                  instr_valid,
  input  logic                  decode_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StWrite,
    StDone
  } state_e;

  state_e                  state_q;
  logic [1:0]              byte_idx_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic                    mem_rd_en_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [7:0]              instruction_q;
  logic [2:0]              ir_write_q;
  logic                    instr_valid_q;
  logic                    busy_q;

  logic [1:0]              byte_idx_d;
  logic [ADDR_WIDTH-1:0]   pc_d;

  assign byte_idx_d = byte_idx_q + 2'd1;
  assign pc_d       = pc_q + ADDR_WIDTH'(4);

  // Outputs are registered alongside the state so they are valid for the whole state cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      byte_idx_q    <= 2'd0;
      pc_q          <= RESET_PC;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      instruction_q <= 8'd0;
      ir_write_q    <= 3'd0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else if (pc_load) begin
      // Redirect drops any partial instruction; a stale memory reply lands outside StWait.
      pc_q          <= pc_load_value;
      byte_idx_q    <= 2'd0;
      ir_write_q    <= 3'd0;
      instr_valid_q <= 1'b0;
      if (run) begin
        state_q     <= StReq;
        mem_rd_en_q <= 1'b1;
        mem_addr_q  <= pc_load_value;
        busy_q      <= 1'b1;
      end else begin
        state_q     <= StIdle;
        mem_rd_en_q <= 1'b0;
        busy_q      <= 1'b0;
      end
    end else begin
      mem_rd_en_q <= 1'b0;
      ir_write_q  <= 3'd0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q     <= StReq;
            byte_idx_q  <= 2'd0;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= pc_q;
            busy_q      <= 1'b1;
          end
        end
        StReq: begin
          state_q <= StWait;
        end
        StWait: begin
          if (mem_valid) begin
            state_q       <= StWrite;
            instruction_q <= mem_data;
            ir_write_q    <= {1'b0, byte_idx_q} + 3'd1;
          end
        end
        StWrite: begin
          if (byte_idx_q != 2'd3) begin
            state_q     <= StReq;
            byte_idx_q  <= byte_idx_d;
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= pc_q + ADDR_WIDTH'(byte_idx_d);
          end else begin
            state_q       <= StDone;
            instr_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (decode_ready) begin
            instr_valid_q <= 1'b0;
            pc_q          <= pc_d;
            byte_idx_q    <= 2'd0;
            if (run) begin
              state_q     <= StReq;
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= pc_d;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign instruction = instruction_q;
  assign ir_write    = ir_write_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: byte memory model with per-address latency,
// event logs of memory requests and IR writes, and hand-computed expectations.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       pc_load;
  logic [7:0] pc_load_value;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic       mem_valid;
  logic [7:0] mem_data;
  logic [7:0] instruction;
  logic [2:0] ir_write;
  logic       instr_valid;
  logic       decode_ready;
  logic [7:0] pc;
  logic       busy;

  fetch_sequencer #(
    .ADDR_WIDTH (8),
    .RESET_PC   (8'h00)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_valid     (mem_valid),
    .mem_data      (mem_data),
    .instruction   (instruction),
    .ir_write      (ir_write),
    .instr_valid   (instr_valid),
    .decode_ready  (decode_ready),
    .pc            (pc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Memory: 1-cycle latency, 3 cycles for slow_addr; a new request replaces a pending one.
  logic [7:0] mem [256];
  logic [7:0] slow_addr;
  logic [7:0] pend_addr = 8'd0;
  int         lat_cnt   = 0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      pend_addr <= mem_addr;
      lat_cnt   <= (mem_addr == slow_addr) ? 3 : 1;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 1;
    end
  end

  assign mem_valid = (lat_cnt == 1);
  assign mem_data  = mem[pend_addr];

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [7:0]  addr_log [$];
  logic [10:0] wr_log   [$];
  int          wr_cyc   [$];
  logic [27:0] ir_model;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mem_rd_en) addr_log.push_back(mem_addr);
    if (ir_write != 3'd0) begin
      wr_log.push_back({ir_write, instruction});
      wr_cyc.push_back(cyc);
      case (ir_write)
        3'd1: ir_model[27:24] = instruction[3:0];
        3'd2: ir_model[23:16] = instruction;
        3'd3: ir_model[15:8]  = instruction;
        3'd4: ir_model[7:0]   = instruction;
        default: ;
      endcase
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    wr_log.delete();
    wr_cyc.delete();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < 64);
    check("valid_reached", {31'd0, instr_valid}, 32'd1);
  endtask

  // Four logged memory requests and IR writes for the instruction at base.
  task automatic check_instr(input string tag, input logic [7:0] base);
    logic [7:0] a;
    check({tag, "_n_req"}, addr_log.size(), 32'd4);
    check({tag, "_n_wr"}, wr_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      a = base + 8'(i);
      check({tag, "_addr"}, {24'd0, addr_log[i]}, {24'd0, a});
      check({tag, "_wr"}, {21'd0, wr_log[i]}, {21'd0, 3'(i + 1), mem[a]});
    end
  endtask

  int n;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h0B; mem[1] = 8'h0E; mem[2] = 8'hAC; mem[3] = 8'h5A;
    mem[9] = 8'hEE;
    slow_addr = 8'h33;
    ir_model = '0;
    rst = 1'b1; run = 1'b0; pc_load = 1'b0; pc_load_value = 8'h00; decode_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_irw", {29'd0, ir_write}, 32'd0);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_instr", {24'd0, instruction}, 32'd0);

    // Basic fetch: first tick leaves IDLE, instr_valid 12 cycles later
    rst = 1'b0;
    run = 1'b1;
    clear_logs();
    wait_valid(n);
    check("basic_latency", n - 1, 32'd12);
    check_instr("basic", 8'h00);
    check("basic_ir", {4'd0, ir_model},
          {4'd0, 5'b10110, 5'b00011, 5'b10101, 5'b01100, 8'h5A});
    check("basic_busy", {31'd0, busy}, 32'd1);

    // Backpressure: held instruction, no new request
    clear_logs();
    repeat (5) tick();
    check("bp_valid", {31'd0, instr_valid}, 32'd1);
    check("bp_pc", {24'd0, pc}, 32'd0);
    check("bp_no_req", addr_log.size(), 32'd0);
    decode_ready = 1'b1;
    tick();
    decode_ready = 1'b0;
    check("bp_pc4", {24'd0, pc}, 32'd4);
    check("bp_valid_lo", {31'd0, instr_valid}, 32'd0);
    check("bp_rd_en", {31'd0, mem_rd_en}, 32'd1);
    check("bp_addr", {24'd0, mem_addr}, 32'd4);

    // Variable latency on byte 2 (address 6): two extra WAIT cycles
    slow_addr = 8'h06;
    clear_logs();
    addr_log.push_back(8'h04);
    wait_valid(n);
    check("slow_latency", n, 32'd14);
    check_instr("slow", 8'h04);
    check("slow_gap", wr_cyc[2] - wr_cyc[1], 32'd5);

    // Redirect while waiting for byte 1 of the instruction at 0x08
    slow_addr = 8'h09;
    decode_ready = 1'b1;
    tick();
    decode_ready = 1'b0;
    check("rd_pc8", {24'd0, pc}, 32'd8);
    repeat (5) tick();
    clear_logs();
    pc_load = 1'b1;
    pc_load_value = 8'h40;
    tick();
    pc_load = 1'b0;
    check("rd_pc", {24'd0, pc}, 32'h40);
    check("rd_rd_en", {31'd0, mem_rd_en}, 32'd1);
    check("rd_irw", {29'd0, ir_write}, 32'd0);
    wait_valid(n);
    check_instr("redir", 8'h40);

    // pc_load beats decode_ready
    pc_load = 1'b1;
    pc_load_value = 8'h80;
    decode_ready = 1'b1;
    tick();
    pc_load = 1'b0;
    decode_ready = 1'b0;
    check("ld_dec_pc", {24'd0, pc}, 32'h80);
    check("ld_dec_valid", {31'd0, instr_valid}, 32'd0);
    check("ld_dec_addr", {24'd0, mem_addr}, 32'h80);

    // Wrap at top of memory, drop run after byte 1 is written
    slow_addr = 8'h33;
    clear_logs();
    pc_load = 1'b1;
    pc_load_value = 8'hFC;
    tick();
    pc_load = 1'b0;
    n = 0;
    while (wr_log.size() < 2 && n < 30) begin
      tick();
      n++;
    end
    run = 1'b0;
    wait_valid(n);
    check_instr("wrap", 8'hFC);
    decode_ready = 1'b1;
    tick();
    decode_ready = 1'b0;
    check("wrap_pc", {24'd0, pc}, 32'd0);
    check("wrap_busy", {31'd0, busy}, 32'd0);
    clear_logs();
    repeat (3) tick();
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_no_req", addr_log.size(), 32'd0);

    // Reset during the WRITE of byte 1, then refetch from byte 0
    run = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (ir_write != 3'd2 && n < 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_irw", {29'd0, ir_write}, 32'd0);
    check("mrst_valid", {31'd0, instr_valid}, 32'd0);
    check("mrst_pc", {24'd0, pc}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    clear_logs();
    wait_valid(n);
    check_instr("refetch", 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream of the instruction register. Fetches each 28-bit instruction as four consecutive bytes from byte-wide instruction memory.
- Presents each byte on `instruction[7:0]` with a one-cycle `ir_write` code (1..4), so the IR assembles opcode/Rs/Rt/Rd/imm.
- Owns the PC: advances it by 4 per instruction, accepts branch redirects, and handshakes with decode via `instr_valid`/`decode_ready`.

Parameters:
- ADDR_WIDTH, 8, width of PC and memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- run  input  1  fetch enable; level-sensitive.
- pc_load  input  1  branch/jump redirect strobe.
- pc_load_value  input  ADDR_WIDTH  redirect target.
- mem_rd_en  output  1  one-cycle read request to instruction memory.
- mem_addr  output  ADDR_WIDTH  byte address of the request.
- mem_valid  input  1  memory data valid (latency ≥1 cycle after mem_rd_en).
- mem_data  input  8  memory read byte.
- instruction  output  8  byte to IR.
- ir_write  output  3  IR byte-slot code: 001 opcode[4:1], 010 opcode[0]/Rs/Rt[4:3], 011 Rt[2:0]/Rd, 100 imm; 000 idle.
- instr_valid  output  1  all four bytes written; instruction ready for decode.
- decode_ready  input  1  decode consumes instruction.
- pc  output  ADDR_WIDTH  address of the instruction being fetched/held.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at posedge, overrides everything):
  - state=IDLE, pc=RESET_PC, byte_idx=0.
  - mem_rd_en=0, mem_addr=0, instruction=0, ir_write=000, instr_valid=0, busy=0.
- All outputs are registered.
- State IDLE: if run=1, go to REQ with byte_idx=0.
- State REQ (1 cycle): mem_rd_en=1, mem_addr=pc+byte_idx (modulo 2^ADDR_WIDTH). Next state is WAIT.
- State WAIT: mem_rd_en=0. On mem_valid=1, capture mem_data and go to WRITE. Otherwise stay in WAIT; there is no timeout.
- State WRITE (1 cycle):
  - instruction=captured byte, ir_write=byte_idx+1.
  - ir_write is nonzero for exactly this one cycle per byte and never repeats a code within one instruction.
  - If byte_idx<3: byte_idx++ and go to REQ. If byte_idx=3: go to DONE.
- State DONE:
  - ir_write=000, instr_valid=1, held until decode_ready=1.
  - On decode_ready: instr_valid→0, pc←pc+4 (wraps), byte_idx←0.
  - Then go to REQ if run=1, else IDLE.
- Latency: with 1-cycle memory, each byte takes 3 cycles (REQ, WAIT, WRITE). instr_valid rises 12 cycles after leaving IDLE.
- run deasserted mid-instruction: the current instruction completes through DONE, then IDLE. No partial IR writes are abandoned.
- pc_load=1 (priority below rst, above all else):
  - pc←pc_load_value, byte_idx←0, ir_write←000, instr_valid←0.
  - Next state is REQ if run=1, else IDLE.
  - An in-flight memory response is discarded: any mem_valid arriving before the new REQ is ignored.
- pc_load and decode_ready in the same cycle: pc_load wins; no pc+4.
- mem_valid outside WAIT is ignored.
- PC wrap: pc=2^ADDR_WIDTH−4 advances to 0. Byte addresses wrap mod 2^ADDR_WIDTH within an instruction.

Test Plan:
- Basic fetch: reset, run=1, memory at 0x00..0x03 = 0x0B,0x0E,0xAC,0x5A with 1-cycle latency.
  - mem_addr sequence is 0,1,2,3.
  - ir_write sequence is 001/0x0B, 010/0x0E, 011/0xAC, 100/0x5A, each for exactly one cycle.
  - The IR ends with opcode=10110, Rs=00011, Rt=10101, Rd=01100, imm=0x5A.
  - instr_valid rises on cycle 12.
- Backpressure: hold decode_ready=0 for 5 cycles after instr_valid.
  - instr_valid stays 1, pc stays 0, no new mem_rd_en.
  - On decode_ready=1, pc=4 and the next mem_addr=4.
- Variable latency: delay mem_valid 3 cycles on byte 2. The FSM holds in WAIT, ir_write stays 000, and correct data is written with code 011.
- Redirect: pc_load=1 with pc_load_value=0x40 while waiting for byte 1 of the instruction at 0x08.
  - The late mem_valid is ignored.
  - The next mem_addr is 0x40 with ir_write starting at 001.
  - pc_load together with decode_ready gives pc=0x40, not 0x0C.
- Wrap and stop: pc_load_value=0xFC, run=1.
  - Addresses are 0xFC..0xFF; after consume, pc=0x00.
  - Drop run during byte 2: the instruction completes, then busy=0 and state is IDLE.
- Reset mid-fetch: rst during WRITE of byte 1 gives ir_write=000, instr_valid=0, pc=RESET_PC next cycle, and refetch starts at byte 0.
